// File: rtl/step_command_gen_if.sv
// Key inputs and step-code outputs of the step command generator.
// The slave side belongs to the generator; the master side drives the keys and reads the code.
interface step_command_gen_if;
    logic KeyUp;
    logic KeyDown;
    logic w1;
    logic w0;
    logic Active;

    modport master (output KeyUp, output KeyDown, input w1, input w0, input Active);
    modport slave  (input KeyUp, input KeyDown, output w1, output w0, output Active);
endinterface

// File: rtl/step_command_gen.sv
// Push-button front end for the mod-9 step counter: sync, debounce and
// hold-to-repeat, emitting single-cycle step codes on w1/w0.
module step_command_gen #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic             Clock,
    input  logic             Reset,
    step_command_gen_if.slave io
);
    localparam int DBW  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;
    localparam logic [DBW-1:0] DB_LAST  = DBW'(DEBOUNCE_CYCLES);
    localparam logic [TW-1:0]  DLY_LAST = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0]  PER_LAST = TW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

    // bit 1 = up key, bit 0 = down key throughout
    logic [1:0]          raw;
    logic [1:0]          s1_q, s2_q;
    logic [1:0]          db_q, db_d;
    logic [1:0][DBW-1:0] cnt_q, cnt_d;
    logic [1:0]          cmb;
    state_t              state_q, state_d;
    logic [TW-1:0]       tmr_q, tmr_d;
    logic [1:0]          lat_q, lat_d;
    logic [1:0]          code_q, code_d;
    logic                active_q, active_d;
    logic                chg;

    assign raw = {io.KeyUp, io.KeyDown};

    // A level is accepted once sync has disagreed with db for DEBOUNCE_CYCLES+1 sampled edges.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            db_d[k]  = db_q[k];
            cnt_d[k] = '0;
            if (s2_q[k] != db_q[k]) begin
                if (cnt_q[k] == DB_LAST) db_d[k] = s2_q[k];
                else                     cnt_d[k] = cnt_q[k] + DBW'(1);
            end
        end
    end

    always_comb begin
        case (db_q)
            2'b10:   cmb = 2'b01;
            2'b01:   cmb = 2'b11;
            2'b11:   cmb = 2'b10;
            default: cmb = 2'b00;
        endcase
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q + TW'(1);
        lat_d   = lat_q;
        code_d  = 2'b00;
        // A change landing right after a pulse waits one cycle so pulses never abut.
        chg     = (cmb != lat_q) && (code_q == 2'b00);
        case (state_q)
            IDLE: begin
                tmr_d = '0;
                if (cmb != 2'b00) begin
                    code_d  = cmb;
                    lat_d   = cmb;
                    state_d = DELAY;
                end
            end
            DELAY: begin
                if (cmb == 2'b00) begin
                    state_d = IDLE;
                    lat_d   = 2'b00;
                    tmr_d   = '0;
                end else if (chg) begin
                    code_d = cmb;
                    lat_d  = cmb;
                    tmr_d  = '0;
                end else if (tmr_q == DLY_LAST) begin
                    code_d  = lat_q;
                    tmr_d   = '0;
                    state_d = REPEAT;
                end
            end
            REPEAT: begin
                if (cmb == 2'b00) begin
                    state_d = IDLE;
                    lat_d   = 2'b00;
                    tmr_d   = '0;
                end else if (chg) begin
                    code_d  = cmb;
                    lat_d   = cmb;
                    tmr_d   = '0;
                    state_d = DELAY;
                end else if (tmr_q == PER_LAST) begin
                    code_d = lat_q;
                    tmr_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
                lat_d   = 2'b00;
                tmr_d   = '0;
            end
        endcase
        active_d = (state_d != IDLE);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            s1_q     <= '0;
            s2_q     <= '0;
            db_q     <= '0;
            cnt_q    <= '0;
            state_q  <= IDLE;
            tmr_q    <= '0;
            lat_q    <= '0;
            code_q   <= '0;
            active_q <= 1'b0;
        end else begin
            s1_q     <= raw;
            s2_q     <= s1_q;
            db_q     <= db_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            lat_q    <= lat_d;
            code_q   <= code_d;
            active_q <= active_d;
        end
    end

    assign io.w1     = code_q[1];
    assign io.w0     = code_q[0];
    assign io.Active = active_q;
endmodule

// File: tb/tb_step_command_gen.sv
// Bench for step_command_gen: directed scenarios plus random key traffic,
// all checked against an event-level model of debounce and repeat timing.
module tb_step_command_gen;
    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic Clock = 1'b0;
    logic Reset;
    step_command_gen_if bus();

    step_command_gen #(.DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .io    (bus)
    );

    always #5 Clock = ~Clock;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // Model: raw history, run-length debounce, and a pulse schedule keyed on absolute edge number.
    bit         m_pu1, m_pu2, m_pd1, m_pd2, m_dbu, m_dbd;
    int         m_ru, m_rd, m_due, m_t;
    logic [1:0] m_w, m_lat, obs_prev;
    int         ecnt;
    int         pe[$];
    int         pc[$];
    int         cnt9;

    function automatic logic [1:0] code_of(input bit u, input bit d);
        if (u && !d) return 2'b01;
        if (!u && d) return 2'b11;
        if (u && d)  return 2'b10;
        return 2'b00;
    endfunction

    task automatic m_reset();
        m_pu1 = 0; m_pu2 = 0; m_pd1 = 0; m_pd2 = 0; m_dbu = 0; m_dbd = 0;
        m_ru = 0; m_rd = 0; m_due = 0; m_t = 0;
        m_w = 2'b00; m_lat = 2'b00; obs_prev = 2'b00;
    endtask

    task automatic start_test();
        ecnt = 0;
        pe.delete();
        pc.delete();
    endtask

    task automatic set_keys(input bit u, input bit d);
        bus.KeyUp   = u;
        bus.KeyDown = d;
    endtask

    task automatic tick();
        logic [1:0] c, pw, obs;
        bit ea;
        c  = code_of(m_dbu, m_dbd);
        ea = (c != 2'b00);
        pw = 2'b00;
        if (c == 2'b00) m_lat = 2'b00;
        else if (m_lat == 2'b00 || (c != m_lat && m_w == 2'b00)) begin
            pw = c; m_lat = c; m_due = m_t + RD;
        end else if (m_t == m_due) begin
            pw = c; m_due = m_t + RP;
        end
        if (m_pu2 != m_dbu) begin
            m_ru++;
            if (m_ru == DB + 1) begin m_dbu = m_pu2; m_ru = 0; end
        end else m_ru = 0;
        if (m_pd2 != m_dbd) begin
            m_rd++;
            if (m_rd == DB + 1) begin m_dbd = m_pd2; m_rd = 0; end
        end else m_rd = 0;
        m_pu2 = m_pu1; m_pu1 = bus.KeyUp;
        m_pd2 = m_pd1; m_pd1 = bus.KeyDown;

        @(posedge Clock);
        #1;
        obs = {bus.w1, bus.w0};
        chk("w", 32'(obs), 32'(pw));
        chk("active", 32'(bus.Active), 32'(ea));
        if (obs != 2'b00 && obs_prev != 2'b00) chk("back_to_back", 32'(obs), 32'd0);
        if (obs != 2'b00) begin
            pe.push_back(ecnt);
            pc.push_back(int'(obs));
            case (obs)
                2'b01:   cnt9 = (cnt9 + 1) % 9;
                2'b10:   cnt9 = (cnt9 + 2) % 9;
                default: cnt9 = (cnt9 + 8) % 9;
            endcase
        end
        obs_prev = obs;
        m_w = pw;
        m_t++;
        ecnt++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press(input bit u, input bit d, input int hold, input int idle);
        set_keys(u, d);
        ticks(hold);
        set_keys(0, 0);
        ticks(idle);
    endtask

    initial begin
        Reset = 1'b1;
        cnt9  = 0;
        set_keys(0, 0);
        m_reset();
        start_test();
        @(posedge Clock);
        #1;
        chk("reset_w", 32'({bus.w1, bus.w0}), 32'd0);
        chk("reset_active", 32'(bus.Active), 32'd0);
        @(posedge Clock);
        #1;
        Reset = 1'b0;

        // single press
        start_test();
        press(1, 0, 10, 20);
        chk("single_npulse", 32'(pe.size()), 32'd1);
        if (pe.size() >= 1) begin
            chk("single_edge", 32'(pe[0]), 32'd7);
            chk("single_code", 32'(pc[0]), 32'd1);
        end

        // bounce rejection
        start_test();
        for (int i = 0; i < 12; i++) begin
            set_keys((i / 2) % 2 == 0, 0);
            tick();
        end
        set_keys(0, 0);
        ticks(15);
        chk("bounce_npulse", 32'(pe.size()), 32'd0);

        // auto-repeat
        start_test();
        press(0, 1, 50, 15);
        chk("repeat_npulse", 32'(pe.size()), 32'd5);
        for (int i = 0; i < 5 && i < pe.size(); i++) begin
            int exp_e [5] = '{7, 27, 35, 43, 51};
            chk("repeat_edge", 32'(pe[i]), 32'(exp_e[i]));
            chk("repeat_code", 32'(pc[i]), 32'd3);
        end

        // combo change restarts the delay
        start_test();
        for (int e = 0; e < 45; e++) begin
            set_keys(1, e >= 12);
            tick();
        end
        set_keys(0, 0);
        ticks(15);
        chk("combo_npulse_ge3", 32'(pe.size() >= 3), 32'd1);
        if (pe.size() >= 3) begin
            chk("combo_e0", 32'(pe[0]), 32'd7);
            chk("combo_c0", 32'(pc[0]), 32'd1);
            chk("combo_e1", 32'(pe[1]), 32'd19);
            chk("combo_c1", 32'(pc[1]), 32'd2);
            chk("combo_e2", 32'(pe[2]), 32'd39);
            chk("combo_c2", 32'(pc[2]), 32'd2);
        end

        // async reset right after a repeat pulse, key kept held
        start_test();
        set_keys(0, 1);
        ticks(28);
        chk("pre_reset_w", 32'({bus.w1, bus.w0}), 32'd3);
        #2;
        Reset = 1'b1;
        #1;
        chk("async_reset_w", 32'({bus.w1, bus.w0}), 32'd0);
        chk("async_reset_active", 32'(bus.Active), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge Clock);
            #1;
            chk("held_reset_w", 32'({bus.w1, bus.w0}), 32'd0);
            chk("held_reset_active", 32'(bus.Active), 32'd0);
        end
        Reset = 1'b0;
        m_reset();
        start_test();
        ticks(12);
        chk("post_reset_npulse", 32'(pe.size()), 32'd1);
        if (pe.size() >= 1) begin
            chk("post_reset_edge", 32'(pe[0]), 32'd7);
            chk("post_reset_code", 32'(pc[0]), 32'd3);
        end
        set_keys(0, 0);
        ticks(15);

        // integration with the mod-9 counter
        cnt9 = 0;
        for (int i = 0; i < 9; i++) press(1, 0, 10, 15);
        chk("count_nine_up", 32'(cnt9), 32'd0);
        cnt9 = 0;
        press(0, 1, 10, 15);
        chk("count_down", 32'(cnt9), 32'd8);
        cnt9 = 7;
        press(1, 1, 10, 15);
        chk("count_both", 32'(cnt9), 32'd0);

        // random key traffic, including short glitches
        for (int s = 0; s < 40; s++) begin
            int cmb, len;
            cmb = int'($urandom_range(0, 3));
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : int'($urandom_range(6, 45));
            set_keys(cmb[1], cmb[0]);
            ticks(len);
        end
        set_keys(0, 0);
        ticks(20);
        chk("final_idle", 32'(bus.Active), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/step_command_gen.md
Name: step_command_gen

Overview:
- Upstream command stage for the mod-9 up/down step counter.
- Converts two raw push-button inputs (KeyUp, KeyDown) into single-cycle step codes on w1/w0.
- Adds 2-flop synchronisation, per-key debounce, and hold-to-auto-repeat.
- w1/w0 connect directly to the counter's w1/w0 inputs. The counter treats 00 as hold, 01 as +1, 10 as +2 and 11 as -1, modulo 9.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable synchronised cycles required to accept a key level change; minimum 1.
- REPEAT_DELAY, 25000000: cycles from the first pulse of a hold to the first repeat pulse; minimum 2.
- REPEAT_PERIOD, 5000000: cycles between successive repeat pulses; minimum 2.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- KeyUp  input  1  raw up button, active-high, asynchronous to Clock.
- KeyDown  input  1  raw down button, active-high, asynchronous to Clock.
- w1  output  1  step code MSB, registered.
- w0  output  1  step code LSB, registered.
- Active  output  1  high while the FSM is not in IDLE, registered.

Behaviour:
- Reset (async, active-high): all flops clear immediately.
  - Synchronisers, debounced levels and timers go to 0; FSM goes to IDLE.
  - w1=0, w0=0, Active=0.
  - Holds while Reset=1 regardless of keys.
- Synchroniser: two flops per key; synchronised value lags the raw input by 2 edges.
- Debounce (per key):
  - Stable level db is initially 0.
  - A counter counts consecutive cycles where sync != db and clears whenever sync == db.
  - On the cycle the count reaches DEBOUNCE_CYCLES, db takes the sync value and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES is discarded.
- Combo to code ({dbUp,dbDn} -> {w1,w0}):
  - 10 -> 01 (+1)
  - 01 -> 11 (-1)
  - 11 -> 10 (+2)
  - 00 -> no command
- Outputs are 00 in every cycle except single-cycle pulses carrying the code. Two consecutive non-zero cycles never occur.
- FSM states:
  - IDLE: Active=0. When combo != 00, emit the code pulse on the next edge, clear the timer and enter DELAY.
  - DELAY: timer increments each cycle.
    - Combo == 00: go to IDLE, no pulse.
    - Combo changes to a different non-zero value: emit the new code, clear the timer, stay in DELAY (treated as a new press).
    - Timer reaches REPEAT_DELAY-1: emit the code, clear the timer, enter REPEAT.
  - REPEAT: timer increments.
    - Combo == 00: go to IDLE.
    - Combo changes to a different non-zero value: emit the new code, go to DELAY with the timer cleared.
    - Timer reaches REPEAT_PERIOD-1: emit the code, clear the timer.
  - Precedence within one cycle: release > combo change > timer expiry.
- Latency:
  - Raw key edge to first pulse = 3+DEBOUNCE_CYCLES edges (2 sync + DEBOUNCE_CYCLES debounce + 1 output register).
  - Subsequent pulses follow at +REPEAT_DELAY, then every +REPEAT_PERIOD.
- Widths: each timer is sized to $clog2 of the larger of its limits; no wrap occurs before expiry.
- Reset mid-hold: keys still held when Reset deasserts must re-qualify through sync and debounce. The first pulse follows 3+DEBOUNCE_CYCLES edges after the first edge with Reset=0.
- Active drops on the edge the FSM enters IDLE.

Test Plan:
- Bench overrides: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8. Edge 0 is the first edge sampling the new raw key value.
- Single press: KeyUp=1 for 10 cycles, then 0 -> exactly one {w1,w0}=01 pulse at edge 7. Active=1 from edge 7 and returns to 0 after the release debounces. No other non-zero cycles.
- Bounce rejection: KeyUp toggles every 2 cycles for 12 cycles, then stays 0 -> w1/w0 stay 00 throughout and Active stays 0.
- Auto-repeat: KeyDown held for 50 cycles -> 11 pulses at edges 7, 27, 35, 43, 51, exactly 5 pulses. Release debounces at edge 56; no pulse at edge 59 and Active=0 afterwards.
- Combo change: hold KeyUp, then also press KeyDown at edge 12 -> 01 at edge 7 and 10 at edge 19. The next 10 pulse comes at edge 39 (delay restarted), not at edge 27.
- Async reset: assert Reset mid-cycle during repeat -> w1/w0=00 and Active=0 before the next edge. Deassert with KeyDown still held -> first 11 pulse 7 edges later.
- Integration with the step counter:
  - Nine separate KeyUp presses starting from count 0 -> count returns to 0.
  - One KeyDown press from 0 -> count 8.
  - One both-keys press from 7 -> count 0.
